// File: rtl/writeback_if.sv
// writeback_if
//   Groups the two handshakes seen by the writeback stage.
//   Result channel (execute -> writeback):
//     wb_valid/wb_ready, wb_result, wb_dest, wb_reg, wb_width,
//     wb_flags_we, wb_status, wb_addr
//   Store channel (writeback -> memory):
//     mem_wr_valid/mem_wr_ready, mem_wr_addr, mem_wr_data, mem_wr_mask
//   Modports:
//     master : the environment (execute stage plus memory port)
//     slave  : the writeback stage itself
interface writeback_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_result;
  logic [1:0]  wb_dest;
  logic [2:0]  wb_reg;
  logic [1:0]  wb_width;
  logic        wb_flags_we;
  logic [4:0]  wb_status;
  logic [31:0] wb_addr;

  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_mask;

  modport master (
    output wb_valid, wb_result, wb_dest, wb_reg, wb_width,
           wb_flags_we, wb_status, wb_addr, mem_wr_ready,
    input  wb_ready, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_mask
  );

  modport slave (
    input  wb_valid, wb_result, wb_dest, wb_reg, wb_width,
           wb_flags_we, wb_status, wb_addr, mem_wr_ready,
    output wb_ready, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_mask
  );
endinterface

// File: rtl/writeback.sv
// writeback
//   Commit stage behind execute. Each accepted result is retired as a
//   GPR merge (8/16/32-bit), a flags-only update, or a memory store.
//   Holds the architectural GPR file and EFLAGS.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : writeback_if.slave (result and store handshakes)
//   gprs      : flat GPR file, reg i at [32i+31:32i]
//   eflags    : architectural EFLAGS
//   wb_err    : sticky flag for illegal width/destination
//   retired   : retired-transaction count
// Optional feature:
//   WB_RETIRE_CNT_EN - when defined, retired counts completed
//   transactions; otherwise retired is tied to zero.
module writeback #(
  parameter logic [31:0] EFLAGS_RST = 32'h0000_0002,
  parameter int          NREGS      = 8
) (
  input  logic               clk,
  input  logic               rst,
  writeback_if.slave         bus,
  output logic [32*NREGS-1:0] gprs,
  output logic [31:0]        eflags,
  output logic               wb_err,
  output logic [31:0]        retired
);

  typedef enum logic {IDLE, STORE} state_t;

  state_t      state;
  logic [31:0] regs [NREGS];
  logic        wb_ready_q;
  logic        mem_wr_valid_q;
  logic [31:0] mem_wr_addr_q;
  logic [31:0] mem_wr_data_q;
  logic [3:0]  mem_wr_mask_q;

  logic        accept;
  logic        illegal;
  logic [2:0]  tgt;
  logic [31:0] merged;
  logic [3:0]  store_mask;

  assign bus.wb_ready     = wb_ready_q;
  assign bus.mem_wr_valid = mem_wr_valid_q;
  assign bus.mem_wr_addr  = mem_wr_addr_q;
  assign bus.mem_wr_data  = mem_wr_data_q;
  assign bus.mem_wr_mask  = mem_wr_mask_q;

  // wb_ready is only ever high in IDLE, so accept implies IDLE.
  assign accept  = bus.wb_valid & wb_ready_q;
  assign illegal = (bus.wb_width == 2'b11) | (bus.wb_dest == 2'b11);

  // Byte writes to regs 4-7 land in byte 1 of regs 0-3 (AH/CH/DH/BH),
  // so the target register drops the high index bit for 8-bit width.
  always_comb begin
    tgt        = (bus.wb_width == 2'b00) ? {1'b0, bus.wb_reg[1:0]} : bus.wb_reg;
    merged     = regs[tgt];
    store_mask = 4'b1111;
    case (bus.wb_width)
      2'b00: begin
        store_mask = 4'b0001;
        if (bus.wb_reg[2]) merged[15:8] = bus.wb_result[7:0];
        else               merged[7:0]  = bus.wb_result[7:0];
      end
      2'b01: begin
        store_mask    = 4'b0011;
        merged[15:0]  = bus.wb_result[15:0];
      end
      default: merged = bus.wb_result;
    endcase
  end

  // Commit FSM; all architectural state and handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wb_ready_q     <= 1'b1;
      mem_wr_valid_q <= 1'b0;
      mem_wr_addr_q  <= '0;
      mem_wr_data_q  <= '0;
      mem_wr_mask_q  <= '0;
      eflags         <= EFLAGS_RST;
      wb_err         <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.wb_flags_we) begin
              eflags[0]  <= bus.wb_status[4];
              eflags[2]  <= bus.wb_status[3];
              eflags[6]  <= bus.wb_status[2];
              eflags[7]  <= bus.wb_status[1];
              eflags[11] <= bus.wb_status[0];
            end
            if (illegal) begin
              wb_err <= 1'b1;
            end else if (bus.wb_dest == 2'b01) begin
              regs[tgt] <= merged;
            end else if (bus.wb_dest == 2'b10) begin
              mem_wr_addr_q  <= bus.wb_addr;
              mem_wr_data_q  <= bus.wb_result;
              mem_wr_mask_q  <= store_mask;
              mem_wr_valid_q <= 1'b1;
              wb_ready_q     <= 1'b0;
              state          <= STORE;
            end
          end
        end
        STORE: begin
          if (bus.mem_wr_ready) begin
            mem_wr_valid_q <= 1'b0;
            wb_ready_q     <= 1'b1;
            state          <= IDLE;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign gprs[32*g +: 32] = regs[g];
  end

`ifdef WB_RETIRE_CNT_EN
  logic retire_evt;

  // Stores retire on the memory handshake, everything else on accept.
  assign retire_evt = (accept & ~(~illegal & (bus.wb_dest == 2'b10))) |
                      ((state == STORE) & bus.mem_wr_ready);

  always_ff @(posedge clk) begin
    if (rst)             retired <= '0;
    else if (retire_evt) retired <= retired + 32'd1;
  end
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_writeback.sv
// tb_writeback
//   Randomized and directed bench for writeback, checked against a
//   register-file/flags/store model kept in the bench.
module tb_writeback;

`ifdef WB_RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] gprs;
  logic [31:0]  eflags;
  logic         wb_err;
  logic [31:0]  retired;

  writeback_if bus ();

  writeback dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .gprs   (gprs),
    .eflags (eflags),
    .wb_err (wb_err),
    .retired(retired)
  );

  always #5 clk = ~clk;

  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [31:0] mRegs [8];
  logic [31:0] mFlags;
  logic        mErr;
  logic [31:0] mRetired;

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] modelFlat();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = mRegs[i];
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mRegs[i] = '0;
    mFlags   = 32'h0000_0002;
    mErr     = 1'b0;
    mRetired = '0;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_gprs"}, gprs, modelFlat());
    checkOutput({tag, "_eflags"}, {224'b0, eflags}, {224'b0, mFlags});
    checkOutput({tag, "_err"}, {255'b0, wb_err}, {255'b0, mErr});
    checkOutput({tag, "_retired"}, {224'b0, retired}, {224'b0, CNT_EN ? mRetired : 32'b0});
  endtask

  task automatic idleInputs();
    bus.wb_valid     = 1'b0;
    bus.wb_result    = '0;
    bus.wb_dest      = '0;
    bus.wb_reg       = '0;
    bus.wb_width     = '0;
    bus.wb_flags_we  = 1'b0;
    bus.wb_status    = '0;
    bus.wb_addr      = '0;
    bus.mem_wr_ready = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelReset();
  endtask

  // Drives one transaction, completes its store handshake after readyDelay
  // stalled cycles, and updates the model from the architectural rules.
  task automatic applyStimulus(input logic [1:0] dest, input logic [1:0] width,
                               input logic [2:0] rg, input logic [31:0] result,
                               input logic [4:0] status, input logic fwe,
                               input logic [31:0] addr, input int readyDelay);
    int  waited;
    bit  bad;
    bit  isStore;
    logic [3:0] expMask;
    bus.wb_result   = result;
    bus.wb_dest     = dest;
    bus.wb_reg      = rg;
    bus.wb_width    = width;
    bus.wb_flags_we = fwe;
    bus.wb_status   = status;
    bus.wb_addr     = addr;
    bus.wb_valid    = 1'b1;
    waited = 0;
    while (bus.wb_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (bus.wb_ready !== 1'b1) begin
      checkOutput("accept_wait", {255'b0, bus.wb_ready}, {255'b0, 1'b1});
      bus.wb_valid = 1'b0;
      return;
    end
    tick();
    bus.wb_valid = 1'b0;

    bad     = (width == 2'd3) || (dest == 2'd3);
    isStore = !bad && dest == 2'd2;
    if (fwe) begin
      mFlags[0]  = status[4];
      mFlags[2]  = status[3];
      mFlags[6]  = status[2];
      mFlags[7]  = status[1];
      mFlags[11] = status[0];
    end
    if (bad) mErr = 1'b1;
    if (!bad && dest == 2'd1) begin
      if (width == 2'd2)      mRegs[rg] = result;
      else if (width == 2'd1) mRegs[rg][15:0] = result[15:0];
      else if (rg < 3'd4)     mRegs[rg][7:0] = result[7:0];
      else                    mRegs[rg - 3'd4][15:8] = result[7:0];
    end
    if (!isStore) mRetired = mRetired + 32'd1;

    if (isStore) begin
      expMask = (width == 2'd0) ? 4'b0001 : (width == 2'd1) ? 4'b0011 : 4'b1111;
      for (int i = 0; i <= readyDelay; i++) begin
        checkOutput("st_valid", {255'b0, bus.mem_wr_valid}, {255'b0, 1'b1});
        checkOutput("st_addr", {224'b0, bus.mem_wr_addr}, {224'b0, addr});
        checkOutput("st_data", {224'b0, bus.mem_wr_data}, {224'b0, result});
        checkOutput("st_mask", {252'b0, bus.mem_wr_mask}, {252'b0, expMask});
        checkOutput("st_busy", {255'b0, bus.wb_ready}, {255'b0, 1'b0});
        bus.mem_wr_ready = (i == readyDelay);
        tick();
      end
      bus.mem_wr_ready = 1'b0;
      mRetired = mRetired + 32'd1;
      checkOutput("st_done_valid", {255'b0, bus.mem_wr_valid}, {255'b0, 1'b0});
      checkOutput("st_done_ready", {255'b0, bus.wb_ready}, {255'b0, 1'b1});
    end
    checkState("txn");
  endtask

  initial begin
    idleInputs();
    rst = 1'b0;
    modelReset();
    doReset();

    checkState("reset");
    checkOutput("reset_ready", {255'b0, bus.wb_ready}, {255'b0, 1'b1});
    checkOutput("reset_memvalid", {255'b0, bus.mem_wr_valid}, {255'b0, 1'b0});
    checkOutput("reset_eflags_const", {224'b0, eflags}, {224'b0, 32'h0000_0002});

    applyStimulus(2'd1, 2'd2, 3'd0, 32'hDEADBEEF, 5'd0, 1'b0, 32'd0, 0);
    applyStimulus(2'd1, 2'd1, 3'd0, 32'h0000_1234, 5'd0, 1'b0, 32'd0, 0);
    applyStimulus(2'd1, 2'd0, 3'd4, 32'h0000_0077, 5'd0, 1'b0, 32'd0, 0);
    checkOutput("merge_reg0", {224'b0, gprs[31:0]}, {224'b0, 32'hDEAD7734});

    applyStimulus(2'd0, 2'd2, 3'd0, 32'h0, 5'b10101, 1'b1, 32'd0, 0);

    applyStimulus(2'd2, 2'd1, 3'd0, 32'h0000_ABCD, 5'd0, 1'b0, 32'h1000, 3);

    // Back-to-back stores with immediate ready.
    applyStimulus(2'd2, 2'd0, 3'd0, 32'h1111_2222, 5'd0, 1'b0, 32'h2000, 0);
    applyStimulus(2'd2, 2'd2, 3'd0, 32'h3333_4444, 5'd0, 1'b0, 32'h2004, 0);

    // Reset while a store is pending.
    bus.wb_result = 32'h5555_6666;
    bus.wb_dest   = 2'd2;
    bus.wb_width  = 2'd2;
    bus.wb_addr   = 32'h3000;
    bus.wb_valid  = 1'b1;
    tick();
    bus.wb_valid = 1'b0;
    checkOutput("midst_valid", {255'b0, bus.mem_wr_valid}, {255'b0, 1'b1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelReset();
    checkOutput("midst_after_valid", {255'b0, bus.mem_wr_valid}, {255'b0, 1'b0});
    checkOutput("midst_after_ready", {255'b0, bus.wb_ready}, {255'b0, 1'b1});
    checkOutput("midst_after_addr", {224'b0, bus.mem_wr_addr}, {224'b0, 32'h0});
    checkState("midst");

    applyStimulus(2'd1, 2'd2, 3'd3, 32'hCAFE_F00D, 5'd0, 1'b0, 32'd0, 0);
    applyStimulus(2'd1, 2'd3, 3'd3, 32'h1234_5678, 5'b01010, 1'b1, 32'd0, 0);
    checkOutput("illegal_err", {255'b0, wb_err}, {255'b0, 1'b1});

    for (int n = 0; n < 80; n++) begin
      applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), $urandom(), 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), $urandom(), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
